seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Multi-cycle unsigned restoring divider: the inverse-direction companion to the team's adder/compressor datapath. Accepts a dividend/divisor pair on a start handshake and retires one quotient bit per clock using a ripple subtract chain built from the team's `full_adder` cells (a + ~b + 1). It returns quotient, remainder and a divide-by-zero flag, with a one-cycle done pulse. It sits beside the multiplier/compressor blocks as the shared division resource.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted on a rising edge where ready=1
- dividend  input  WIDTH  unsigned dividend, sampled on accept
- divisor  input  WIDTH  unsigned divisor, sampled on accept
- ready  output  1  high when a start will be accepted (state≠RUN)
- busy  output  1  high while iterating (state=RUN)
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  registered quotient, held until next completion
- remainder  output  WIDTH  registered remainder, held until next completion
- div_by_zero  output  1  registered: last completed operation had divisor=0

## Operation
- States: IDLE, RUN, DONE. On reset: IDLE.
- Accept (IDLE or DONE, start=1): latch D=divisor, Q=dividend, R=0 (WIDTH+1 bits), cnt=WIDTH, zflag=(divisor==0); go RUN.
- In IDLE with start=0: stay IDLE. In DONE with start=0: go IDLE.
- RUN, each edge: R'={R[WIDTH-1:0],Q[WIDTH-1]}; diff=R'−{1'b0,D} via full_adder chain, carry-in 1. If diff[WIDTH]=0: R=diff, Q={Q[WIDTH-2:0],1}; else R=R', Q={Q[WIDTH-2:0],0}. cnt decrements.
- When the edge performing the last iteration (cnt=1) occurs: load quotient=Q_next, remainder=R_next[WIDTH-1:0], div_by_zero=zflag; go DONE.
- start while RUN: ignored, not queued.
- Divisor 0 via normal iteration yields quotient=all ones, remainder=dividend.
- Arithmetic purely unsigned; remainder < divisor whenever divisor≠0.

## Timing
- Reset values: ready=1, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.
- Accept at edge t → busy=1 from t to t+WIDTH; done=1 and results valid for exactly the cycle after edge t+WIDTH (latency WIDTH+1 cycles start-to-done).
- ready=0 only during RUN; ready=1 in DONE cycle, so start there is accepted (back-to-back, one done per operation, throughput one op per WIDTH+1 cycles).
- Results change only on transition into DONE; held through IDLE and the next RUN.
- rst mid-RUN: next edge returns all outputs to reset values; no done is issued for the aborted operation.
- rst and start on the same edge: rst wins, start dropped.

## Configuration
- DIVIDER_ZERO_FAST_EN defined: on accept with divisor=0, go directly to DONE; the accept edge loads quotient=all ones, remainder=dividend, div_by_zero=1; done the next cycle (latency 1); busy never asserts.
- Undefined: divisor=0 runs the full WIDTH iterations; identical result values and div_by_zero=1, latency WIDTH+1.

## Test plan
- WIDTH=8, 100/7 → quotient=14, remainder=2, div_by_zero=0; done exactly 9 cycles after accept, busy high 8 cycles.
- 255/1 → 255,0; 5/9 → 0,5; 255/255 → 1,0; 0/3 → 0,0.
- 200/0 → quotient=255, remainder=200, div_by_zero=1; done at cycle 1 with DIVIDER_ZERO_FAST_EN, cycle 9 without.
- Start 100/7 then pulse start with 50/5 during RUN → single done with 14,2; second request ignored.
- Start asserted in DONE cycle with 50/5 → first done 14,2, then second done 9 cycles later with 10,0.
- rst asserted at iteration 4 of 100/7 → outputs at reset values next cycle, no done; fresh 9/2 afterwards → 4,1.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock via a full_adder chain.
// Optional DIVIDER_ZERO_FAST_EN: divisor=0 completes on the accept edge.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] nd;

  // Partial remainder stays below the divisor, so WIDTH bits hold it;
  // the shifted value needs one extra bit for the trial subtract.
  assign r_sh     = {r_q, q_q[WIDTH-1]};
  assign nd       = ~d_q;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    full_adder u_fa (
      .a_i (r_sh[i]),
      .b_i (nd[i]),
      .c_i (carry[i]),
      .s_o (diff[i]),
      .c_o (carry[i+1])
    );
  end

  // Top bit of divisor is an implicit 0, inverted to 1.
  assign diff[WIDTH] = ~(r_sh[WIDTH] ^ carry[WIDTH]);

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = CW'(WIDTH);
          z_d     = (divisor == '0);
          state_d = RUN;
`ifdef DIVIDER_ZERO_FAST_EN
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
        r_d   = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = z_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q != RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases plus random ops
// against an arithmetic reference (/ and %).
module tb_seq_restoring_divider;
  localparam int W = 8;
`ifdef DIVIDER_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] hq = '0;
  logic [W-1:0] hr = '0;
  logic         hz = 1'b0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quo"}, quotient, 0);
    chk({tag, "_rem"}, remainder, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask

  // Called with ready=1 (IDLE, or the DONE cycle for back-to-back).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int bsy;
    int elat;
    int ebsy;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq   = (b == 0) ? {W{1'b1}} : W'(a / b);
    er   = (b == 0) ? a : W'(a % b);
    elat = (FAST && b == 0) ? 1 : W + 1;
    ebsy = (FAST && b == 0) ? 0 : W;
    chk("ready_pre", ready, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 1;
    bsy = 0;
    if (!done) begin
      chk("held_quo", quotient, hq);
      chk("held_rem", remainder, hr);
      chk("held_dbz", div_by_zero, hz);
    end
    while (!done && lat < 4 * W) begin
      if (busy) bsy++;
      tick();
      lat++;
    end
    chk("done_seen", done, 1);
    chk("latency", lat, elat);
    chk("busy_cycles", bsy, ebsy);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, b == 0);
    chk("ready_done", ready, 1);
    hq = eq;
    hr = er;
    hz = (b == 0);
  endtask

  initial begin
    int nd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    run_op(100, 7);
    tick();
    chk("pulse_done", done, 0);
    chk("pulse_quo", quotient, 14);
    run_op(255, 1);
    run_op(5, 9);
    run_op(255, 255);
    run_op(0, 3);
    run_op(200, 0);
    tick();

    // start during RUN is dropped
    start    = 1'b1;
    dividend = 100;
    divisor  = 7;
    tick();
    start = 1'b0;
    tick();
    tick();
    start    = 1'b1;
    dividend = 50;
    divisor  = 5;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        nd++;
        chk("ign_quo", quotient, 14);
        chk("ign_rem", remainder, 2);
      end
      tick();
    end
    chk("ign_done_count", nd, 1);
    hq = 14;
    hr = 2;
    hz = 1'b0;

    // back-to-back: second start lands in the DONE cycle
    run_op(100, 7);
    run_op(50, 5);
    tick();

    // reset mid-run, with a simultaneous start
    start    = 1'b1;
    dividend = 100;
    divisor  = 7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 9;
    divisor  = 2;
    tick();
    chk_reset("rst_mid");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_dropped", busy, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    chk("rst_no_done", nd, 0);
    hq = '0;
    hr = '0;
    hz = 1'b0;
    run_op(9, 2);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      run_op(a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
